rr_mux_reg: RTL
===============

# rr_mux_reg

Parametrised N-channel, W-bit multiplexer with valid/ready handshakes, an arbiter, and a registered output stage. It generalises the fixed 8:1 32-bit select mux used in the processor datapath. Instead of taking an external select, it chooses among requesting sources itself, using either round-robin or fixed-priority arbitration. The chosen word, and the index of the channel it came from, are held in one output register. Typical use: merging several request streams, such as memory-port or writeback sources, into a single consumer.

## Interface
- WIDTH, 32, data width of every channel and of the output
- CHANNELS, 8, number of input channels (2..16)
- SEL_BITS, 3, width of out_sel; must equal ceil(log2(CHANNELS))
- ROUND_ROBIN, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  CHANNELS  bit i set = channel i presents a word
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  CHANNELS  one-hot or zero; bit i = channel i's word is accepted this cycle
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered word
- out_sel  output  SEL_BITS  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Transfer rule:
  - Input transfer on channel i when in_valid[i] & in_ready[i].
  - Output transfer when out_valid & out_ready.
- load = ~out_valid | out_ready. The output register may capture a new word this cycle.
- Arbitration (combinational each cycle over in_valid):
  - Fixed priority: grant goes to the lowest index i with in_valid[i].
  - Round-robin: search starts at (last+1) mod CHANNELS, wraps, and grants the first valid channel found. last is the most recently transferred channel index.
- in_ready = grant & {CHANNELS{load}}.
  - At most one bit is set.
  - in_ready is zero when no channel is valid, or when the register is full and not draining.
- On the edge after an input transfer from channel g:
  - out_data <= word of g
  - out_sel <= g
  - out_valid <= 1
  - last <= g (round-robin mode only)
- Output transfer with no simultaneous input transfer: out_valid <= 0. out_data and out_sel hold their values.
- Simultaneous input and output transfer: the register is replaced and out_valid stays 1. This sustains one word per cycle.
- last updates only on an input transfer. An idle cycle or a stalled consumer never advances it.
- Words from any single channel leave in their arrival order. No word is duplicated or dropped.

## Timing
- Reset state, effective on the first edge with reset high:
  - out_valid = 0, out_data = 0, out_sel = 0
  - last = CHANNELS-1, so channel 0 has first priority after reset
- in_ready is forced to 0 while reset is high.
- Latency: a word accepted at edge k appears on out_data with out_valid=1 after edge k. It may be consumed at edge k+1.
- Throughput: 1 word/cycle while out_ready=1 and any channel is valid.
- in_ready depends combinationally on in_valid, out_valid and out_ready, with no path from in_data. out_* are driven directly from registers.
- Backpressure:
  - With out_valid=1 and out_ready=0, all in_ready = 0 and the output register holds steady.
  - Sources must keep in_valid and in_data stable until their transfer.
- Reset asserted mid-stream discards the held word and restores the reset state on that edge. The next transfer is arbitrated from channel 0.
- Round-robin fairness: with all CHANNELS continuously valid and out_ready=1, each channel is granted exactly once in every CHANNELS consecutive transfers.

## Test plan
- Reset then idle:
  - Stimulus: reset high 2 cycles, then in_valid=0.
  - Required: out_valid=0, out_data=0, out_sel=0, in_ready=0 on every cycle.
- Single channel:
  - Stimulus: in_valid=8'b0000_0100, channel 2 data=32'hDEAD_BEEF, out_ready=1.
  - Required: in_ready=8'b0000_0100 on the first cycle. Next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_sel=2.
- Round-robin sweep:
  - Stimulus: all 8 channels valid, channel i data=i, out_ready=1, 16 cycles.
  - Required: out_sel sequence is 0,1,…,7,0,…,7 and out_data equals out_sel, one word per cycle.
- Fixed priority (ROUND_ROBIN=0):
  - Stimulus: channels 3 and 5 valid continuously, out_ready=1.
  - Required: only channel 3 is ever granted and out_sel=3 every cycle.
- Backpressure:
  - Stimulus: channel 1 data=32'h11 valid. After the word is captured, hold out_ready=0 for 3 cycles while channel 6 data=32'h66 is also valid; then out_ready=1.
  - Required: in_ready=0 and out_data=32'h11 held for the 3 stalled cycles. The handoff cycle shows out_data=32'h11. The next cycle shows out_data=32'h66, out_sel=6.
- Reset mid-stream:
  - Stimulus: out_valid=1 with out_sel=4, assert reset for one cycle, then all channels valid.
  - Required: after the reset edge out_valid=0. The first post-reset output has out_sel=0.

Source files
------------

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel, W-bit arbitrated multiplexer with valid/ready
// handshakes. A single output register holds the selected word and the
// index of the channel it came from. Arbitration is either round-robin
// (search starts just after the last channel transferred) or fixed
// priority (lowest index wins).
module rr_mux_reg #(
  parameter int WIDTH       = 32,
  parameter int CHANNELS    = 8,
  parameter int SEL_BITS    = 3,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_BITS-1:0]       out_sel,
  input  logic                      out_ready
);

  // Output register and arbitration history.
  logic                out_valid_reg;
  logic [WIDTH-1:0]    out_data_reg;
  logic [SEL_BITS-1:0] out_sel_reg;
  logic [SEL_BITS-1:0] last_reg;

  // Combinational arbitration results.
  logic                grant_any;
  logic [SEL_BITS-1:0] grant_idx;
  logic [CHANNELS-1:0] grant_vec;
  logic                load;

  // Per-channel view of the flat input data bus.
  logic [WIDTH-1:0]    chan_data [CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // The register can take a new word when it is empty or being drained.
  assign load = ~out_valid_reg | out_ready;

  // Arbiter: walk the channels in priority order and take the first valid
  // one. Round-robin starts one past the last transferred channel; fixed
  // priority always starts at channel 0. Depends only on in_valid and
  // last_reg, never on in_data.
  always_comb begin
    int c;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ROUND_ROBIN) begin
        c = int'(last_reg) + 1 + k;
        if (c >= CHANNELS) c = c - CHANNELS;
      end else begin
        c = k;
      end
      if (!grant_any && in_valid[c]) begin
        grant_any    = 1'b1;
        grant_idx    = SEL_BITS'(c);
        grant_vec[c] = 1'b1;
      end
    end
  end

  // Accept the granted word only when the register can load; reset blocks
  // all handshakes so nothing is lost across a reset edge.
  always_comb begin
    in_ready = '0;
    if (!reset) begin
      in_ready = grant_vec & {CHANNELS{load}};
    end
  end

  // Output register: capture on an input transfer, empty on a lone output
  // transfer, otherwise hold. A simultaneous accept and drain replaces the
  // word, sustaining one word per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      last_reg      <= SEL_BITS'(CHANNELS - 1);
    end else if (grant_any && load) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= chan_data[grant_idx];
      out_sel_reg   <= grant_idx;
      if (ROUND_ROBIN) begin
        last_reg <= grant_idx;
      end
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule
